sample_streamer: RTL and testbench

Read-side controller for the single-port sample RAM.
- Issues sequential read commands (`cs`/`we`/`addr`) to the RAM and absorbs its one-cycle registered read latency.
- Delivers samples on a valid/ready stream to the FIR filter input, with full backpressure support and no sample loss or duplication.
- Supports one-shot or looping playback of a contiguous address window.

---
 rtl/fir_pkg.sv | 13 +
 rtl/skid_fifo2.sv | 63 ++++++
 rtl/sample_streamer.sv | 131 +++++++++++++
 tb/tb_sample_streamer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Types and default widths shared by the sample RAM and its read-side streamer.
package fir_pkg;

   localparam int DEF_A_WIDTH = 16;
   localparam int DEF_D_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } streamer_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO used as the streamer output buffer; flush empties it in one cycle.
module skid_fifo2 #(
   parameter int W = 25
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_valid,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_mem[gi] <= '0;
            end else if (!i_flush && w_push && (r_wr_ptr == gi[0])) begin
               r_mem[gi] <= i_din;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/sample_streamer.sv
// Streams a contiguous window of the sample RAM onto a valid/ready interface,
// one-shot or looping, absorbing the RAM's one-cycle registered read latency.
module sample_streamer
   import fir_pkg::*;
#(
   parameter int A_WIDTH = DEF_A_WIDTH,
   parameter int D_WIDTH = DEF_D_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] base_addr,
   input  logic [A_WIDTH:0]   num_samples,
   input  logic               loop_en,
   input  logic               abort,
   output logic               ram_cs,
   output logic               ram_we,
   output logic [A_WIDTH-1:0] ram_addr,
   output logic [D_WIDTH-1:0] ram_w_data,
   input  logic [D_WIDTH-1:0] ram_r_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [D_WIDTH-1:0] m_data,
   output logic               m_last,
   output logic               busy,
   output logic               done
);

   streamer_state_t    r_state;
   logic [A_WIDTH-1:0] r_base;
   logic [A_WIDTH-1:0] r_idx;
   logic [A_WIDTH:0]   r_num;
   logic               r_loop;
   logic               r_inflight;
   logic               r_inflight_last;
   logic               r_done;

   logic               w_pop;
   logic               w_flush;
   logic               w_issue;
   logic               w_is_last;
   logic               w_credit_ok;
   logic [1:0]         w_count;
   logic [D_WIDTH:0]   w_fifo_dout;

   assign w_pop     = m_valid & m_ready;
   assign w_flush   = abort && (r_state != IDLE);
   assign w_is_last = ({1'b0, r_idx} == (r_num - {{A_WIDTH{1'b0}}, 1'b1}));

   // A read is allowed only if buffer entries plus the pending read still leave room after this cycle's pop.
   assign w_credit_ok = ({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
   assign w_issue     = (r_state == RUN) && !abort && w_credit_ok;

   assign ram_cs     = w_issue;
   assign ram_we     = 1'b0;
   assign ram_addr   = r_base + r_idx;
   assign ram_w_data = '0;

   skid_fifo2 #(
      .W(D_WIDTH + 1)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (r_inflight),
      .i_din   ({r_inflight_last, ram_r_data}),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_valid (m_valid),
      .o_count (w_count)
   );

   assign m_data = w_fifo_dout[D_WIDTH-1:0];
   assign m_last = w_fifo_dout[D_WIDTH];
   assign busy   = (r_state != IDLE);
   assign done   = r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_base          <= '0;
         r_idx           <= '0;
         r_num           <= '0;
         r_loop          <= 1'b0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_done          <= 1'b0;
         r_inflight      <= w_issue;
         r_inflight_last <= w_is_last;
         case (r_state)
            IDLE: begin
               if (start && (num_samples != '0)) begin
                  r_base  <= base_addr;
                  r_num   <= num_samples;
                  r_loop  <= loop_en;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state <= IDLE;
               end else if (w_issue) begin
                  if (w_is_last) begin
                     r_idx <= '0;
                     if (!r_loop) begin
                        r_state <= DRAIN;
                     end
                  end else begin
                     r_idx <= r_idx + {{(A_WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  r_state <= IDLE;
               end else if (r_done) begin
                  r_state <= IDLE;
               end else begin
                  // Pulse done in the cycle after the final entry leaves with nothing behind it.
                  r_done <= !r_inflight && (w_count == 2'd1) && w_pop;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_streamer.sv
// Randomized bench for sample_streamer against a window/sequence reference model.
module tb_sample_streamer;

   localparam int AW    = 6;
   localparam int DW    = 24;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_samples;
   logic          loop_en;
   logic          abort;
   logic          ram_cs;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_w_data;
   logic [DW-1:0] ram_r_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          done;

   sample_streamer #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .num_samples (num_samples),
      .loop_en     (loop_en),
      .abort       (abort),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_w_data  (ram_w_data),
      .ram_r_data  (ram_r_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_cs && !ram_we) ram_r_data <= mem[ram_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: the pass is the window base..base+N-1 (mod DEPTH), repeated when looping.
   int  m_base, m_n;
   bit  m_loop;
   int  rd_cnt, hs_cnt, done_cnt;
   bit  mon_en = 1'b0;
   int  cyc = 0;
   int  start_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;
   bit  prev_stall = 1'b0;
   bit  busy_chk_pending = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   int  pos;
   int  ready_mode = 1;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = $urandom_range(0, 1) == 1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (ram_cs) begin
            chk("ram_we", {31'b0, ram_we}, 0);
            chk("ram_w_data", {8'b0, ram_w_data}, 0);
            if (!m_loop && rd_cnt >= m_n) chk("extra_read", rd_cnt, m_n - 1);
            else chk("ram_addr", {26'b0, ram_addr}, (m_base + rd_cnt % m_n) % DEPTH);
            rd_cnt++;
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            chk("stall_valid", {31'b0, m_valid}, 1);
            chk("stall_data", {8'b0, m_data}, {8'b0, prev_data});
            chk("stall_last", {31'b0, m_last}, {31'b0, prev_last});
         end
         if (m_valid && m_ready) begin
            if (!m_loop && hs_cnt >= m_n) chk("extra_sample", hs_cnt, m_n - 1);
            else begin
               pos = hs_cnt % m_n;
               chk("m_data", {8'b0, m_data}, {8'b0, mem[(m_base + pos) % DEPTH]});
               chk("m_last", {31'b0, m_last}, (pos == m_n - 1) ? 1 : 0);
            end
            $display("sample %0d data=0x%06h last=%0b cycle=%0d", hs_cnt, m_data, m_last, cyc);
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
         end
         if (ram_cs || (m_valid && m_ready)) chk("buffered_le2", (rd_cnt - hs_cnt <= 2) ? 1 : 0, 1);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end else begin
         prev_stall = 1'b0;
      end
      if (busy_chk_pending) begin
         chk("busy_after_done", {31'b0, busy}, 0);
         chk("valid_after_done", {31'b0, m_valid}, 0);
         busy_chk_pending = 1'b0;
      end
      if (done) begin
         done_cnt++;
         if (mon_en) begin
            chk("done_oneshot", {31'b0, m_loop}, 0);
            chk("done_count", hs_cnt, m_n);
            chk("done_timing", cyc - last_hs_cyc, 1);
            busy_chk_pending = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ram_cs", {31'b0, ram_cs}, 0);
      chk("rst_ram_addr", {26'b0, ram_addr}, 0);
      chk("rst_m_valid", {31'b0, m_valid}, 0);
      chk("rst_m_data", {8'b0, m_data}, 0);
      chk("rst_m_last", {31'b0, m_last}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
   endtask

   // Model of a completed one-shot: any read, sample or done that follows is an error.
   task automatic expect_quiet();
      m_n = 1; m_loop = 1'b0; rd_cnt = 1; hs_cnt = 1; mon_en = 1'b1;
   endtask

   task automatic start_run(input int b, input int n, input bit lp);
      m_base = b; m_n = n; m_loop = lp;
      rd_cnt = 0; hs_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = 0;
      base_addr = AW'(b); num_samples = (AW+1)'(n); loop_en = lp;
      start = 1'b1; mon_en = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
      $display("start base=%0d n=%0d loop=%0b", b, n, lp);
      chk("busy_after_start", {31'b0, busy}, 1);
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while (done_cnt == 0 && t < budget) begin
         tick();
         t++;
      end
      chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
      tick();
      tick();
      chk("done_single", done_cnt, 1);
   endtask

   task automatic do_abort();
      abort = 1'b1; mon_en = 1'b0;
      tick();
      abort = 1'b0;
      chk("abort_valid", {31'b0, m_valid}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_cs", {31'b0, ram_cs}, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
      base_addr = '0; num_samples = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h100);
      tick();
      chk_reset_outputs();
      tick();
      rst = 1'b0;
      tick();

      // Basic one-shot
      ready_mode = 1;
      start_run(4, 8, 1'b0);
      wait_done(60);
      chk("latency", first_valid_cyc - start_cyc, 2);
      chk("oneshot_no_bubbles", last_hs_cyc - first_hs_cyc, 7);

      // Address wrap past the top of the RAM
      start_run(62, 4, 1'b0);
      wait_done(60);

      // Random backpressure
      fill_random();
      ready_mode = 2;
      start_run(int'($urandom_range(0, DEPTH - 1)), 32, 1'b0);
      wait_done(600);
      chk("bp_count", hs_cnt, 32);

      // Looping playback
      ready_mode = 1;
      start_run(10, 3, 1'b1);
      for (int t = 0; t < 80 && hs_cnt < 10; t++) tick();
      chk("loop_hs", (hs_cnt >= 10) ? 1 : 0, 1);
      chk("loop_no_bubbles", last_hs_cyc - first_hs_cyc, hs_cnt - 1);
      chk("loop_no_done", done_cnt, 0);
      do_abort();
      repeat (4) tick();
      chk("abort_no_done", done_cnt, 0);

      // Abort with a stalled, full buffer, then restart from address 0
      ready_mode = 0;
      start_run(20, 10, 1'b0);
      repeat (6) tick();
      chk("stalled_valid", {31'b0, m_valid}, 1);
      do_abort();
      repeat (3) tick();
      chk("abort2_no_done", done_cnt, 0);
      ready_mode = 1;
      tick();
      start_run(0, 5, 1'b0);
      wait_done(60);
      chk("restart_latency", first_valid_cyc - start_cyc, 2);

      // Reset in the middle of a run
      start_run(5, 20, 1'b0);
      repeat (5) tick();
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      tick();
      rst = 1'b0;
      tick();

      // start with N=0 must be ignored
      expect_quiet();
      base_addr = 3; num_samples = '0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("n0_busy", {31'b0, busy}, 0);
      repeat (3) tick();
      chk("n0_cs", {31'b0, ram_cs}, 0);

      // start while busy must be ignored
      ready_mode = 2;
      start_run(7, 12, 1'b0);
      repeat (3) tick();
      base_addr = 40; num_samples = 5; loop_en = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0; loop_en = 1'b0;
      wait_done(300);

      // Full-depth window and random one-shots
      ready_mode = 1;
      start_run(17, DEPTH, 1'b0);
      wait_done(120);
      chk("full_no_bubbles", last_hs_cyc - first_hs_cyc, DEPTH - 1);
      for (int r = 0; r < 5; r++) begin
         int n;
         fill_random();
         ready_mode = int'($urandom_range(1, 2));
         n = int'($urandom_range(1, DEPTH));
         start_run(int'($urandom_range(0, DEPTH - 1)), n, 1'b0);
         wait_done(n * 8 + 40);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
